spi_register_writer: RTL and testbench

SPI_REGISTER_WRITER -- requirements
Module: spi_register_writer

---
 rtl/spi_register_writer.sv | 135 +++++++++++++
 tb/tb_spi_register_writer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_register_writer.sv
// SPI mode-0 slave that turns 24-bit frames into synth register write strobes.
// Optional echo of the last committed frame on MISO: define SPI_REGISTER_ECHO_EN.
module spi_register_writer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_SPI_Clock,
    input  logic        i_SPI_CS_n,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterWriteNumber,
    output logic [7:0]  o_RegisterWriteValue,
    output logic        o_FrameError
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_prev;
    logic                   sck_s, cs_s, mosi_s, sck_rise;
    logic [4:0]             bit_cnt, bit_cnt_nxt;
    logic [23:0]            shift_sr, shift_nxt;
    logic                   commit_load, err_nxt;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_SPI_Clock};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;

    // Chip-select release is checked before the SCK edge so it always wins.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_sr;
        commit_load = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    state_nxt   = SHIFT;
                    bit_cnt_nxt = 5'd0;
                    shift_nxt   = 24'd0;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_nxt   = IDLE;
                    err_nxt     = (bit_cnt != 5'd0);
                    bit_cnt_nxt = 5'd0;
                end else if (sck_rise) begin
                    shift_nxt = {shift_sr[22:0], mosi_s};
                    if (bit_cnt == 5'd23) begin
                        state_nxt   = COMMIT;
                        bit_cnt_nxt = 5'd0;
                        commit_load = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
            end
            COMMIT: begin
                state_nxt   = cs_s ? IDLE : SHIFT;
                bit_cnt_nxt = 5'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state                 <= IDLE;
            bit_cnt               <= 5'd0;
            shift_sr              <= 24'd0;
            o_RegisterWriteNumber <= 16'd0;
            o_RegisterWriteValue  <= 8'd0;
            o_FrameError          <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift_sr     <= shift_nxt;
            o_FrameError <= err_nxt;
            if (commit_load) begin
                o_RegisterWriteNumber <= shift_nxt[23:8];
                o_RegisterWriteValue  <= shift_nxt[7:0];
            end
        end
    end

    assign o_RegisterWriteEnable = (state == COMMIT);

`ifdef SPI_REGISTER_ECHO_EN
    logic [23:0] echo_q;
    logic        miso_q;
    logic        sck_fall;

    assign sck_fall = ~sck_s & sck_prev;

    // bit_cnt is the number of bits already received, i.e. the next echo bit index from the MSB.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            echo_q <= 24'd0;
            miso_q <= 1'b0;
        end else begin
            if (commit_load)
                echo_q <= shift_nxt;
            if (state == IDLE && !cs_s)
                miso_q <= echo_q[23];
            else if (state != IDLE && !cs_s && sck_fall)
                miso_q <= echo_q[5'd23 - bit_cnt];
        end
    end

    assign o_SPI_MISO = miso_q;
`else
    assign o_SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_register_writer.sv
// Directed bench for spi_register_writer: strobe scoreboard, frame errors, reset and echo.
module tb_spi_register_writer;

    localparam int  SYNC_STAGES = 2;
    localparam time TCLK        = 10;
    localparam time THALF       = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck, cs_n, mosi;
    logic        miso, we, ferr;
    logic [15:0] num;
    logic [7:0]  val;

    logic [23:0] exp_q[$];
    logic [23:0] exp_e;
    logic [23:0] miso_cap;
    time         last_rise_t = 0;
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;

    spi_register_writer #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .i_Clock               (clk),
        .i_Reset               (rst),
        .i_SPI_Clock           (sck),
        .i_SPI_CS_n            (cs_n),
        .i_SPI_MOSI            (mosi),
        .o_SPI_MISO            (miso),
        .o_RegisterWriteEnable (we),
        .o_RegisterWriteNumber (num),
        .o_RegisterWriteValue  (val),
        .o_FrameError          (ferr)
    );

    always #(TCLK/2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] echo_exp(input logic [23:0] v);
`ifdef SPI_REGISTER_ECHO_EN
        return v;
`else
        return 24'd0 & v;
`endif
    endfunction

    // Monitor: every strobe pops one expected frame.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got number %0h value %0h expected no strobe", num, val);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("strobe_number", {16'd0, num}, {16'd0, exp_e[23:8]});
                    check("strobe_value", {24'd0, val}, {24'd0, exp_e[7:0]});
                    check("strobe_latency", {31'd0, ($time - last_rise_t) <= (SYNC_STAGES + 2) * TCLK}, 32'd1);
                end
            end
            if (ferr === 1'b1) err_seen++;
        end
    end

    task automatic send_bits(input logic [23:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = data[23-i];
            #THALF;
            miso_cap = {miso_cap[22:0], miso};
            sck = 1'b1;
            last_rise_t = $time;
            #THALF;
            sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [23:0] data);
        exp_q.push_back(data);
        send_bits(data, 24);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        miso_cap = 24'd0;
        #(2*THALF);
    endtask

    task automatic cs_high();
        #THALF;
        cs_n = 1'b1;
        #200;
    endtask

    initial begin
        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        #32;
        check("reset_we", {31'd0, we}, 32'd0);
        check("reset_number", {16'd0, num}, 32'd0);
        check("reset_value", {24'd0, val}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_miso", {31'd0, miso}, 32'd0);
        rst = 1'b0;
        #40;

        // single frame
        cs_low();
        frame(24'hC1237F);
        check("miso_first_frame", {8'd0, miso_cap}, 32'd0);
        cs_high();
        check("ferr_after_frame", err_seen, 0);

        // two frames under one chip select
        cs_low();
        frame(24'h400001);
        check("miso_b2b_1", {8'd0, miso_cap}, {8'd0, echo_exp(24'hC1237F)});
        frame(24'hC42480);
        check("miso_b2b_2", {8'd0, miso_cap}, {8'd0, echo_exp(24'h400001)});
        cs_high();
        check("hold_number", {16'd0, num}, 32'hC424);
        check("hold_value", {24'd0, val}, 32'h80);

        // aborted partial frame then a good one
        cs_low();
        send_bits(24'hABCDEF, 13);
        cs_high();
        check("ferr_after_abort", err_seen, 1);
        check("state_after_abort", int'(dut.state), 0);
        cs_low();
        frame(24'hC001AA);
        check("miso_after_abort", {8'd0, miso_cap}, {8'd0, echo_exp(24'hC42480)});
        cs_high();
        check("ferr_after_good", err_seen, 1);

        // reset in the middle of a frame
        cs_low();
        send_bits(24'h123456, 10);
        #7 rst = 1'b1;
        #1;
        check("midreset_we", {31'd0, we}, 32'd0);
        check("midreset_number", {16'd0, num}, 32'd0);
        check("midreset_value", {24'd0, val}, 32'd0);
        check("midreset_ferr", {31'd0, ferr}, 32'd0);
        cs_n = 1'b1;
        #40;
        rst = 1'b0;
        #200;
        check("ferr_after_reset", err_seen, 1);
        cs_low();
        frame(24'h5A5AA5);
        check("miso_after_reset", {8'd0, miso_cap}, 32'd0);
        cs_high();

        // SCK activity with chip select high
        repeat (10) begin
            #THALF sck = 1'b1;
            #THALF sck = 1'b0;
        end
        #100;
        check("idle_sck_state", int'(dut.state), 0);
        check("idle_sck_ferr", err_seen, 1);

        #200;
        check("all_strobes_seen", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
